// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// ALU operation classes and mux select / fault codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    JR        = 4'd12,
    TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG_A  = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // States that own the shared memory port and therefore wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mctrl_wait_timer.sv
// Counts consecutive stalled cycles in a memory state and flags a timeout when
// the limit is reached with the memory still not ready (MEM_TIMEOUT=0 disables).
module mctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  input  logic state_change,
  output logic timeout
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (state_change) begin
      count <= '0;
    end else if (waiting && !mem_ready) begin
      count <= count + CNT_W'(1);
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign timeout = 1'b0;
    end else begin : g_timeout
      // A completing access in the limit cycle suppresses the timeout.
      assign timeout = waiting && !mem_ready && (count == CNT_W'(MEM_TIMEOUT));
    end
  endgenerate

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM sharing one memory port for fetch and data.
// Optional performance counters are enabled by defining MCTRL_PERF_EN.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic       is_jal,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic [1:0] fault
`ifdef MCTRL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_retired
`endif
);

  state_t     cur_state, next_state;
  logic [1:0] fault_next;
  logic       timeout;

  mctrl_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clock       (clock),
    .reset       (reset),
    .waiting     (is_mem_state(cur_state)),
    .mem_ready   (mem_ready),
    .state_change(next_state != cur_state),
    .timeout     (timeout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state <= FETCH;
      fault     <= FAULT_NONE;
    end else begin
      cur_state <= next_state;
      fault     <= fault_next;
    end
  end

  assign state = cur_state;

  // NOTE: every output and next-state term gets a default before the case so
  // no path through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state = cur_state;
    fault_next = fault;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = REG_DST_RT;
    reg_write  = 1'b0;
    is_jal     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_source  = PC_ALU;

    // Outputs are gated by the asynchronous reset itself so nothing can pulse
    // between reset assertion and the next clock edge.
    if (reset) begin
      unique case (cur_state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = DECODE;
          end else if (timeout) begin
            next_state = TRAP;
            fault_next = FAULT_TIMEOUT;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE:      next_state = (funct == FUNCT_JR) ? JR : R_EXEC;
            OP_LW, OP_SW:  next_state = MEM_ADDR;
            OP_BEQ, OP_BNE: next_state = BRANCH;
            OP_J, OP_JAL:  next_state = JUMP;
            OP_ADDI:       next_state = I_EXEC;
            default: begin
              next_state = TRAP;
              fault_next = FAULT_ILLEGAL;
            end
          endcase
        end
        MEM_ADDR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          next_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) begin
            next_state = MEM_WB;
          end else if (timeout) begin
            next_state = TRAP;
            fault_next = FAULT_TIMEOUT;
          end
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          next_state = FETCH;
        end
        MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            next_state = FETCH;
          end else if (timeout) begin
            next_state = TRAP;
            fault_next = FAULT_TIMEOUT;
          end
        end
        R_EXEC: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_RTYPE;
          next_state = R_WB;
        end
        R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RD;
          next_state = FETCH;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_source  = PC_ALUOUT;
          pc_write   = (opcode == OP_BNE) ? !zero : zero;
          next_state = FETCH;
        end
        JUMP: begin
          pc_source = PC_JUMP;
          pc_write  = 1'b1;
          if (opcode == OP_JAL) begin
            reg_write = 1'b1;
            reg_dst   = REG_DST_RA;
            is_jal    = 1'b1;
          end
          next_state = FETCH;
        end
        I_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          next_state = I_WB;
        end
        I_WB: begin
          reg_write  = 1'b1;
          next_state = FETCH;
        end
        JR: begin
          pc_source  = PC_REG_A;
          pc_write   = 1'b1;
          next_state = FETCH;
        end
        TRAP: begin
          next_state = TRAP;
        end
        default: begin
          next_state = TRAP;
          fault_next = FAULT_ILLEGAL;
        end
      endcase
    end
  end

`ifdef MCTRL_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count   <= '0;
      instr_retired <= '0;
    end else begin
      if (cur_state != TRAP) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if ((next_state == FETCH) && (cur_state != FETCH)) begin
        instr_retired <= instr_retired + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore/Mealy sequencer that drives the MIPS datapath as a multi-cycle machine, using one shared memory port for both instruction fetch and data access.
- Decodes the latched opcode and funct fields, then steps through fetch, decode, execute, memory and writeback states, emitting per-cycle enables and mux selects.
- Stalls on a memory ready handshake, and traps on an illegal opcode or on a memory timeout.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive wait cycles with mem_ready=0 in a memory state before the block traps; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; it must hold MEM_TIMEOUT.

Ports:
- clock in 1: rising-edge clock, the only clock.
- reset in 1: asynchronous, active-low reset.
- opcode in 6: instruction[31:26], taken from the instruction register.
- funct in 6: instruction[5:0], used only to detect jr.
- zero in 1: ALU zero flag.
- mem_ready in 1: memory completes the current access this cycle.
- pc_write out 1: load PC.
- ir_write out 1: load the instruction register.
- i_or_d out 1: memory address select; 0 = PC, 1 = ALUOut.
- mem_read out 1: memory read request.
- mem_write out 1: memory write request.
- mem_to_reg out 1: register write data select; 1 = MDR.
- reg_dst out 2: destination register select; 00 = rt, 01 = rd, 10 = $31.
- reg_write out 1: register file write enable.
- is_jal out 1: write data = PC+4.
- alu_src_a out 1: ALU A input; 0 = PC, 1 = A register.
- alu_src_b out 2: ALU B input; 00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op out 3: ALU operation class fed to the ALU control.
- pc_source out 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A register.
- state out 4: current state, for debug.
- fault out 2: sticky fault code; 00 = none, 01 = illegal opcode, 10 = memory timeout.

Behaviour:
- Reset, while reset=0: state=FETCH, wait counter=0, fault=00, every control output forced to 0. After release, the FETCH outputs appear in the first cycle.
- Asynchronous reset mid-operation aborts the sequence immediately; no write enable may pulse during or after assertion.
- Memory handshake: a request (mem_read or mem_write) holds steady until the cycle in which mem_ready=1. The state advances only on that cycle.
  - pc_write and ir_write in FETCH, and reg data capture in MEM_READ, are Mealy outputs gated by mem_ready.
- FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. On mem_ready: ir_write=1, pc_write=1, go to DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes the branch target into ALUOut). Dispatch on opcode:
  - R-type(000000), funct=001000 -> JR.
  - Other R-type -> R_EXEC.
  - lw(100011) or sw(101011) -> MEM_ADDR.
  - beq(000100) or bne(000101) -> BRANCH.
  - j(000010) or jal(000011) -> JUMP.
  - addi(001000) -> I_EXEC.
  - Anything else -> TRAP with fault=01.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=ADD. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ(3): mem_read=1, i_or_d=1. On mem_ready go to MEM_WB.
- MEM_WB(4): reg_write=1, reg_dst=00, mem_to_reg=1. Go to FETCH.
- MEM_WRITE(5): mem_write=1, i_or_d=1. On mem_ready go to FETCH.
- R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=RTYPE. Go to R_WB.
- R_WB(7): reg_write=1, reg_dst=01, mem_to_reg=0. Go to FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01. pc_write = zero for beq, !zero for bne. Go to FETCH.
- JUMP(9): pc_source=10, pc_write=1. For jal also reg_write=1, reg_dst=10, is_jal=1. Go to FETCH.
- I_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op=ADD. Go to I_WB.
- I_WB(11): reg_write=1, reg_dst=00, mem_to_reg=0. Go to FETCH.
- JR(12): pc_source=11, pc_write=1. Go to FETCH.
- TRAP(13): all enables 0; terminal until reset.
- Any unused state encoding goes to TRAP with fault=01.
- Wait counter:
  - Increments each cycle the block is in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on every state change.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP with fault=10.
  - If mem_ready=1 arrives in the same cycle as the limit, completion wins.
- Outputs not listed for a state are 0.

Optional Feature:
- MCTRL_PERF_EN defined: adds outputs cycle_count[31:0] and instr_retired[31:0].
  - cycle_count increments every non-reset cycle except in TRAP.
  - instr_retired increments on each transition into FETCH from a non-FETCH state.
  - Both wrap at 2^32 and clear on reset.
- MCTRL_PERF_EN undefined: these ports and their counters do not exist.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings (FETCH..TRAP);
  - opcode constants (RTYPE, LW, SW, BEQ, BNE, J, JAL, ADDI) and FUNCT_JR;
  - alu_op encodings (ADD=000, SUB=001, RTYPE=010);
  - pc_source, reg_dst and fault encodings.
- One natural sub-module, mctrl_wait_timer: the wait counter plus the timeout compare.

Test Plan:
- lw with mem_ready delayed 2 cycles in FETCH and 0 cycles in MEM_READ -> states 0,0,0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1.
- beq with zero=1, then bne with zero=1 -> pc_write=1 with pc_source=01 for beq; pc_write=0 for bne; both return to FETCH.
- jal (opcode 000011) -> JUMP asserts pc_write=1, reg_write=1, reg_dst=10, is_jal=1 for exactly one cycle.
- mem_ready held 0 in MEM_WRITE with MEM_TIMEOUT=15 -> TRAP after 15 wait cycles, fault=10, mem_write drops to 0; mem_ready=1 on cycle 15 instead completes normally.
- opcode 111111 -> DECODE goes to TRAP with fault=01, all enables stay 0 until reset.
- Reset pulled low mid-MEM_READ -> all outputs 0 immediately; after release, state=FETCH and mem_read=1 on the next cycle.
